// File: rtl/spi_sample_sequencer.sv
// Periodic SPI frame launcher: drives the controller start/idle handshake,
// buffers received frames in a FIFO and tracks overruns, drops and hangs.
module spi_sample_sequencer #(
  parameter int FRAME_WIDTH    = 32,
  parameter int PERIOD_CYCLES  = 1000,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [FRAME_WIDTH-1:0] tx_word_i,
  output logic                   ctrl_start_o,
  input  logic                   ctrl_idle_i,
  input  logic                   ctrl_cs_i,
  input  logic [FRAME_WIDTH-1:0] ctrl_rx_i,
  output logic [FRAME_WIDTH-1:0] ctrl_tx_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [FRAME_WIDTH-1:0] m_data_o,
  output logic                   overrun_o,
  output logic                   timeout_o,
  output logic [15:0]            drop_count_o
);
  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BUSY, S_CAPTURE, S_RELEASE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [FRAME_WIDTH-1:0] tx_q, tx_d;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic tmo_q, tmo_d;
  logic [15:0] drop_q, drop_d, drop_base;
  logic [FRAME_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;

  logic tick, leave_idle, waiting;
  logic push, pop, full, accept, fdrop;
  logic ovr_ev, tmo_ev, tmo_drop;
  logic [1:0] n_ev;

  assign tick       = enable_i && (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = (!enable_i || tick) ? '0 : tick_cnt_q + 1'b1;

  // A tick in the same cycle counts as pending so start follows it directly.
  assign ovr_ev = tick && pend_q;
  assign pend_d = leave_idle ? 1'b0 : (pend_q || tick);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    leave_idle = 1'b0;
    push       = 1'b0;
    tmo_ev     = 1'b0;
    tmo_drop   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((pend_q || tick) && ctrl_idle_i) begin
          state_d    = S_START;
          tx_d       = tx_word_i;
          leave_idle = 1'b1;
        end
      end
      S_START:   if (!ctrl_idle_i) state_d = S_BUSY;
      S_BUSY:    if (ctrl_cs_i && !ctrl_idle_i) state_d = S_CAPTURE;
      S_CAPTURE: begin
        push    = 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: if (ctrl_idle_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    waiting = (state_q == S_START) || (state_q == S_BUSY)
           || (state_q == S_RELEASE);
    if (waiting && state_d == state_q && wd_q == WD_LAST) begin
      tmo_ev   = 1'b1;
      tmo_drop = (state_q != S_RELEASE);
      state_d  = (state_q == S_RELEASE) ? S_IDLE : S_RELEASE;
    end
    wd_d = (waiting && state_d == state_q) ? wd_q + 1'b1 : '0;
  end

  assign pop    = (cnt_q != '0) && m_ready_i;
  assign full   = (cnt_q == FULL_CNT);
  assign accept = push && (!full || pop);
  assign fdrop  = push && full && !pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (accept) wr_d = wr_q + 1'b1;
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear is applied first so a same-cycle event still lands.
  always_comb begin
    n_ev      = 2'(ovr_ev) + 2'(fdrop) + 2'(tmo_drop);
    drop_base = clear_i ? '0 : drop_q;
    if (drop_base > 16'hFFFF - 16'(n_ev)) drop_d = 16'hFFFF;
    else drop_d = drop_base + 16'(n_ev);
    ovr_d = (ovr_q && !clear_i) || ovr_ev;
    tmo_d = (tmo_q && !clear_i) || tmo_ev;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      wd_q       <= '0;
      tx_q       <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wd_q       <= wd_d;
      tx_q       <= tx_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_q] <= ctrl_rx_i;
  end

  assign ctrl_start_o = (state_q == S_START) || (state_q == S_BUSY)
                     || (state_q == S_CAPTURE);
  assign ctrl_tx_o    = tx_q;
  assign m_valid_o    = (cnt_q != '0);
  assign m_data_o     = m_valid_o ? mem_q[rd_q] : '0;
  assign overrun_o    = ovr_q;
  assign timeout_o    = tmo_q;
  assign drop_count_o = drop_q;
endmodule
